// File: rtl/vector_cache_pkg.sv
// Shared vector-cache types: address, evict request, RAM line and downstream beat.
// Also holds the evict serializer beat count and its FSM state type.
package vector_cache_pkg;

    localparam int LINE_WIDTH     = 1024;
    localparam int BUS_WIDTH      = 128;
    localparam int TAG_WIDTH      = 20;
    localparam int INDEX_WIDTH    = 8;
    localparam int OFFSET_WIDTH   = 9;
    localparam int ROB_ID_WIDTH   = 6;
    localparam int DB_ID_WIDTH    = 5;
    localparam int TXNID_WIDTH    = 8;
    localparam int SIDEBAND_WIDTH = 10;
    localparam int EVICT_BEAT_NUM = LINE_WIDTH / BUS_WIDTH;

    typedef struct packed {
        logic [TAG_WIDTH-1:0]    tag;
        logic [INDEX_WIDTH-1:0]  index;
        logic [OFFSET_WIDTH-1:0] offset;
    } addr_t;

    typedef struct packed {
        addr_t                     addr;
        logic [ROB_ID_WIDTH-1:0]   rob_entry_id;
        logic [DB_ID_WIDTH-1:0]    db_entry_id;
        logic [TXNID_WIDTH-1:0]    txnid;
        logic [SIDEBAND_WIDTH-1:0] sideband;
    } evict_req_pld_t;

    typedef struct packed {
        logic [LINE_WIDTH-1:0] data;
        evict_req_pld_t        evict_req_pld;
    } ram_to_evdb_pld_t;

    typedef struct packed {
        logic [BUS_WIDTH-1:0]      data;
        addr_t                     addr;
        logic                      last;
        logic [ROB_ID_WIDTH-1:0]   rob_entry_id;
        logic [DB_ID_WIDTH-1:0]    db_entry_id;
        logic [TXNID_WIDTH-1:0]    txnid;
        logic [SIDEBAND_WIDTH-1:0] sideband;
    } evict_to_ds_pld_t;

    typedef enum logic {
        EVS_IDLE = 1'b0,
        EVS_SEND = 1'b1
    } evict_ser_state_e;

endpackage

// File: rtl/evict_ds_serializer.sv
// Splits an evicted 1024-bit line into BUS_WIDTH downstream beats.
// EVICT_SER_DOUBLE_BUF_EN adds a pending line entry for zero-bubble streaming.
module evict_ds_serializer
    import vector_cache_pkg::*;
#(
    parameter int BEAT_NUM = EVICT_BEAT_NUM
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    output logic             in_rdy,
    input  ram_to_evdb_pld_t in_pld,
    output logic             out_vld,
    input  logic             out_rdy,
    output evict_to_ds_pld_t out_pld,
    output logic             busy
);

    localparam int CNT_W = $clog2(BEAT_NUM);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEAT_NUM - 1);
    localparam logic [OFFSET_WIDTH-1:0] BEAT_BYTES = OFFSET_WIDTH'(BUS_WIDTH / 8);

    evict_ser_state_e state_q, state_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    ram_to_evdb_pld_t cur_q;
    ram_to_evdb_pld_t load_pld;
    logic             load_cur;
    logic             in_hs;
    logic             out_hs;
    logic             last_hs;

`ifdef EVICT_SER_DOUBLE_BUF_EN
    ram_to_evdb_pld_t pend_q;
    logic             pend_vld_q, pend_vld_d;
    logic             pend_load;

    assign in_rdy = !pend_vld_q;
    assign busy   = (state_q == EVS_SEND) || pend_vld_q;
`else
    assign in_rdy = (state_q == EVS_IDLE);
    assign busy   = (state_q == EVS_SEND);
`endif

    assign out_vld = (state_q == EVS_SEND);
    assign in_hs   = in_vld && in_rdy;
    assign out_hs  = out_vld && out_rdy;
    assign last_hs = out_hs && (beat_q == LAST_BEAT);

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        load_cur = 1'b0;
        load_pld = in_pld;
`ifdef EVICT_SER_DOUBLE_BUF_EN
        pend_vld_d = pend_vld_q;
        pend_load  = 1'b0;
`endif
        unique case (state_q)
            EVS_IDLE: begin
                if (in_hs) begin
                    state_d  = EVS_SEND;
                    beat_d   = '0;
                    load_cur = 1'b1;
                end
            end
            EVS_SEND: begin
                if (out_hs) beat_d = beat_q + 1'b1;
                if (last_hs) begin
                    beat_d = '0;
`ifdef EVICT_SER_DOUBLE_BUF_EN
                    // Last beat hands over to the pending line, or straight to a
                    // line arriving this very cycle, so no bubble is inserted.
                    if (pend_vld_q) begin
                        load_cur   = 1'b1;
                        load_pld   = pend_q;
                        pend_vld_d = 1'b0;
                    end else if (in_hs) begin
                        load_cur = 1'b1;
                    end else begin
                        state_d = EVS_IDLE;
                    end
`else
                    state_d = EVS_IDLE;
`endif
                end
`ifdef EVICT_SER_DOUBLE_BUF_EN
                else if (in_hs) begin
                    pend_load  = 1'b1;
                    pend_vld_d = 1'b1;
                end
`endif
            end
            default: state_d = EVS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EVS_IDLE;
            beat_q  <= '0;
`ifdef EVICT_SER_DOUBLE_BUF_EN
            pend_vld_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
`ifdef EVICT_SER_DOUBLE_BUF_EN
            pend_vld_q <= pend_vld_d;
`endif
        end
    end

    // Line payload is qualified by the valid state, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load_cur) cur_q <= load_pld;
`ifdef EVICT_SER_DOUBLE_BUF_EN
        if (pend_load) pend_q <= in_pld;
`endif
    end

    always_comb begin
        out_pld              = '0;
        out_pld.data         = cur_q.data[beat_q*BUS_WIDTH +: BUS_WIDTH];
        out_pld.addr.tag     = cur_q.evict_req_pld.addr.tag;
        out_pld.addr.index   = cur_q.evict_req_pld.addr.index;
        out_pld.addr.offset  = cur_q.evict_req_pld.addr.offset
                             + OFFSET_WIDTH'(beat_q) * BEAT_BYTES;
        out_pld.last         = (beat_q == LAST_BEAT);
        out_pld.rob_entry_id = cur_q.evict_req_pld.rob_entry_id;
        out_pld.db_entry_id  = cur_q.evict_req_pld.db_entry_id;
        out_pld.txnid        = cur_q.evict_req_pld.txnid;
        out_pld.sideband     = cur_q.evict_req_pld.sideband;
    end

endmodule

// File: tb/tb_evict_ds_serializer.sv
// Self-checking bench for evict_ds_serializer: directed vectors, stall,
// back-to-back, mid-transfer reset and randomized traffic vs a queue model.
module tb_evict_ds_serializer;
    import vector_cache_pkg::*;

    localparam int NB = EVICT_BEAT_NUM;
`ifdef EVICT_SER_DOUBLE_BUF_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_vld = 1'b0;
    logic             in_rdy;
    ram_to_evdb_pld_t in_pld;
    logic             out_vld;
    logic             out_rdy = 1'b0;
    evict_to_ds_pld_t out_pld;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    evict_ds_serializer #(.BEAT_NUM(NB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .in_pld  (in_pld),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .out_pld (out_pld),
        .busy    (busy)
    );

    typedef struct {
        logic [OFFSET_WIDTH-1:0]   off;
        logic [TAG_WIDTH-1:0]      tag;
        logic [INDEX_WIDTH-1:0]    idx;
        logic [ROB_ID_WIDTH-1:0]   rob;
        logic [DB_ID_WIDTH-1:0]    db;
        logic [TXNID_WIDTH-1:0]    txn;
        logic [SIDEBAND_WIDTH-1:0] sb;
        logic [OFFSET_WIDTH-1:0]   exp_off [8];
    } vec_t;

    vec_t tbl [4];
    evict_to_ds_pld_t q [$];

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic ram_to_evdb_pld_t mk_line(
        input logic [OFFSET_WIDTH-1:0] off, input logic [TAG_WIDTH-1:0] tag,
        input logic [INDEX_WIDTH-1:0] idx, input logic [ROB_ID_WIDTH-1:0] rob,
        input logic [DB_ID_WIDTH-1:0] db, input logic [TXNID_WIDTH-1:0] txn,
        input logic [SIDEBAND_WIDTH-1:0] sb, input bit rnd);
        ram_to_evdb_pld_t l;
        logic [7:0] kb;
        for (int k = 0; k < NB; k++) begin
            kb = 8'(k);
            l.data[k*BUS_WIDTH +: BUS_WIDTH] = {16{kb}};
        end
        if (rnd)
            for (int i = 0; i < LINE_WIDTH / 32; i++)
                l.data[i*32 +: 32] = $urandom;
        l.evict_req_pld.addr.offset  = off;
        l.evict_req_pld.addr.tag     = tag;
        l.evict_req_pld.addr.index   = idx;
        l.evict_req_pld.rob_entry_id = rob;
        l.evict_req_pld.db_entry_id  = db;
        l.evict_req_pld.txnid        = txn;
        l.evict_req_pld.sideband     = sb;
        return l;
    endfunction

    function automatic ram_to_evdb_pld_t rnd_line();
        return mk_line(OFFSET_WIDTH'($urandom), TAG_WIDTH'($urandom),
                       INDEX_WIDTH'($urandom), ROB_ID_WIDTH'($urandom),
                       DB_ID_WIDTH'($urandom), TXNID_WIDTH'($urandom),
                       SIDEBAND_WIDTH'($urandom), 1'b1);
    endfunction

    // Reference beat k of a line: byte-address arithmetic mod 512.
    function automatic evict_to_ds_pld_t exp_beat(input ram_to_evdb_pld_t l,
                                                  input int k);
        evict_to_ds_pld_t b;
        logic [LINE_WIDTH-1:0] sh;
        int o;
        sh = l.data >> (k * BUS_WIDTH);
        o  = (int'(l.evict_req_pld.addr.offset) + k * (BUS_WIDTH / 8)) % 512;
        b.data         = sh[BUS_WIDTH-1:0];
        b.addr.tag     = l.evict_req_pld.addr.tag;
        b.addr.index   = l.evict_req_pld.addr.index;
        b.addr.offset  = OFFSET_WIDTH'(o);
        b.last         = (k == NB - 1);
        b.rob_entry_id = l.evict_req_pld.rob_entry_id;
        b.db_entry_id  = l.evict_req_pld.db_entry_id;
        b.txnid        = l.evict_req_pld.txnid;
        b.sideband     = l.evict_req_pld.sideband;
        return b;
    endfunction

    task automatic accept_line(input ram_to_evdb_pld_t l);
        int n;
        n = 0;
        in_pld = l;
        in_vld = 1'b1;
        while (!in_rdy && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: in_rdy 0 required 1");
        end
        tick();
        in_vld = 1'b0;
    endtask

    initial begin
        ram_to_evdb_pld_t la, lb;
        logic [7:0] kb;
        bit pat [4];
        int idx, beats, first, lastc, sent, cyc;
        bit acc, pop, bsent;

        in_pld = '0;
        tbl[0].off = 9'h000; tbl[0].tag = 20'h12345; tbl[0].idx = 8'h5A;
        tbl[0].rob = 6'h2A;  tbl[0].db = 5'h13;      tbl[0].txn = 8'hC3;
        tbl[0].sb  = 10'h3FF;
        tbl[0].exp_off = '{9'h000, 9'h010, 9'h020, 9'h030,
                           9'h040, 9'h050, 9'h060, 9'h070};
        tbl[1].off = 9'h1F8; tbl[1].tag = 20'hABCDE; tbl[1].idx = 8'hFF;
        tbl[1].rob = 6'h01;  tbl[1].db = 5'h1F;      tbl[1].txn = 8'h00;
        tbl[1].sb  = 10'h155;
        tbl[1].exp_off = '{9'h1F8, 9'h008, 9'h018, 9'h028,
                           9'h038, 9'h048, 9'h058, 9'h068};
        tbl[2].off = 9'h1F0; tbl[2].tag = 20'h00001; tbl[2].idx = 8'h00;
        tbl[2].rob = 6'h3F;  tbl[2].db = 5'h00;      tbl[2].txn = 8'hFF;
        tbl[2].sb  = 10'h000;
        tbl[2].exp_off = '{9'h1F0, 9'h000, 9'h010, 9'h020,
                           9'h030, 9'h040, 9'h050, 9'h060};
        tbl[3].off = 9'h0A8; tbl[3].tag = 20'hF0F0F; tbl[3].idx = 8'h81;
        tbl[3].rob = 6'h15;  tbl[3].db = 5'h0A;      tbl[3].txn = 8'h5A;
        tbl[3].sb  = 10'h2AA;
        tbl[3].exp_off = '{9'h0A8, 9'h0B8, 9'h0C8, 9'h0D8,
                           9'h0E8, 9'h0F8, 9'h108, 9'h118};

        // Reset state
        #12;
        chk("rst_out_vld", out_vld, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_rdy", in_rdy, 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Directed vectors
        out_rdy = 1'b1;
        for (int r = 0; r < 4; r++) begin
            la = mk_line(tbl[r].off, tbl[r].tag, tbl[r].idx, tbl[r].rob,
                         tbl[r].db, tbl[r].txn, tbl[r].sb, 1'b0);
            accept_line(la);
            for (int k = 0; k < 8; k++) begin
                kb = 8'(k);
                chk($sformatf("v%0d_b%0d_vld", r, k), out_vld, 1'b1);
                chk($sformatf("v%0d_b%0d_data", r, k), out_pld.data, {16{kb}});
                chk($sformatf("v%0d_b%0d_off", r, k), out_pld.addr.offset,
                    tbl[r].exp_off[k]);
                chk($sformatf("v%0d_b%0d_last", r, k), out_pld.last, k == 7);
                chk($sformatf("v%0d_b%0d_tag", r, k), out_pld.addr.tag, tbl[r].tag);
                chk($sformatf("v%0d_b%0d_idx", r, k), out_pld.addr.index, tbl[r].idx);
                chk($sformatf("v%0d_b%0d_rob", r, k), out_pld.rob_entry_id, tbl[r].rob);
                chk($sformatf("v%0d_b%0d_db", r, k), out_pld.db_entry_id, tbl[r].db);
                chk($sformatf("v%0d_b%0d_txn", r, k), out_pld.txnid, tbl[r].txn);
                chk($sformatf("v%0d_b%0d_sb", r, k), out_pld.sideband, tbl[r].sb);
                tick();
            end
            chk($sformatf("v%0d_end_vld", r), out_vld, 1'b0);
            chk($sformatf("v%0d_end_busy", r), busy, 1'b0);
        end

        // Stall pattern 1,0,0,1
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        la = rnd_line();
        accept_line(la);
        idx = 0;
        for (int c = 0; c < 64 && idx < NB; c++) begin
            out_rdy = pat[c % 4];
            chk($sformatf("stall_c%0d_vld", c), out_vld, 1'b1);
            chk($sformatf("stall_c%0d_pld", c), out_pld, exp_beat(la, idx));
            if (out_rdy) idx++;
            tick();
        end
        chk("stall_beats", idx, NB);
        chk("stall_end_vld", out_vld, 1'b0);

        // Two lines back-to-back with in_vld held high
        out_rdy = 1'b1;
        la = rnd_line();
        lb = rnd_line();
        in_pld = la;
        in_vld = 1'b1;
        tick();
        in_pld = lb;
        chk("b2b_in_rdy_send", in_rdy, DBL);
        beats = 0; first = -1; lastc = -1;
        for (int c = 0; c < 40 && beats < 2 * NB; c++) begin
            if (out_vld) begin
                chk($sformatf("b2b_beat%0d", beats), out_pld,
                    exp_beat(beats < NB ? la : lb, beats % NB));
                if (first < 0) first = c;
                lastc = c;
                beats++;
            end
            bsent = in_vld && in_rdy;
            tick();
            if (bsent) in_vld = 1'b0;
        end
        in_vld = 1'b0;
        chk("b2b_beats", beats, 2 * NB);
        chk("b2b_first", first, 0);
        chk("b2b_span", lastc - first, DBL ? 2 * NB - 1 : 2 * NB);
        tick();
        chk("b2b_idle_busy", busy, 1'b0);

        // Reset asserted while beat 3 is presented
        la = mk_line(9'h100, 20'h11111, 8'h22, 6'h03, 5'h04, 8'h05, 10'h006, 1'b0);
        accept_line(la);
        tick(); tick(); tick();
        chk("rst_mid_off", out_pld.addr.offset, 9'h130);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_vld", out_vld, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_in_rdy", in_rdy, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_post_vld", out_vld, 1'b0);
        lb = mk_line(9'h040, 20'h33333, 8'h44, 6'h07, 5'h08, 8'h09, 10'h00A, 1'b0);
        accept_line(lb);
        chk("rst_post_first_vld", out_vld, 1'b1);
        chk("rst_post_first_pld", out_pld, exp_beat(lb, 0));
        while (out_vld) tick();

        // Randomized traffic vs queue model
        sent = 0;
        for (cyc = 0; cyc < 4000; cyc++) begin
            if (sent == 40 && q.size() == 0 && !in_vld) break;
            if (!in_vld && sent < 40 && $urandom_range(2) == 0) begin
                in_pld = rnd_line();
                in_vld = 1'b1;
            end
            out_rdy = ($urandom_range(3) != 0);
            chk("rnd_vld", out_vld, q.size() != 0);
            chk("rnd_busy", busy, q.size() != 0);
            if (out_vld && q.size() != 0) chk("rnd_pld", out_pld, q[0]);
            acc = in_vld && in_rdy;
            pop = out_vld && out_rdy;
            tick();
            if (pop && q.size() != 0) void'(q.pop_front());
            if (acc) begin
                for (int k = 0; k < NB; k++) q.push_back(exp_beat(in_pld, k));
                in_vld = 1'b0;
                sent++;
            end
        end
        chk("rnd_lines_sent", sent, 40);
        chk("rnd_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/evict_ds_serializer.md
EVICT_DS_SERIALIZER -- requirements
Module: evict_ds_serializer

Interface
REQ-001 SHALL have parameter BEAT_NUM, default 1024/BUS_WIDTH (=8), the number of downstream beats per evicted line.
REQ-002 SHALL have port clk, input, 1, the single clock; all state is clocked on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_vld, input, 1, evict line valid from the RAM read path.
REQ-005 SHALL have port in_rdy, output, 1, serializer can accept a line.
REQ-006 SHALL have port in_pld, input, ram_to_evdb_pld_t, 1024-bit line plus evict_req_pld.
REQ-007 SHALL have port out_vld, output, 1, downstream beat valid.
REQ-008 SHALL have port out_rdy, input, 1, downstream accepts the beat.
REQ-009 SHALL have port out_pld, output, evict_to_ds_pld_t, one BUS_WIDTH beat with addr, last, ids, txnid and sideband.
REQ-010 SHALL have port busy, output, 1, high while any line is buffered or sending.

Function
REQ-011 SHALL accept a line on in_vld&&in_rdy and capture data plus evict_req_pld into a line buffer.
REQ-012 SHALL run FSM IDLE->SEND on accept, SEND->IDLE on the handshake of beat BEAT_NUM-1 when no further line is buffered, and SEND->SEND (beat 0 of the next line) when one is buffered.
REQ-013 SHALL assert out_vld the cycle after accept (latency 1), from registers only.
REQ-014 SHALL drive beat i data = line data[i*BUS_WIDTH +: BUS_WIDTH], with beat 0 taken from the least-significant bits.
REQ-015 SHALL drive addr.tag/index from the request, and addr.offset = req offset + i*(BUS_WIDTH/8), truncated to OFFSET_WIDTH (wraps mod 512).
REQ-016 SHALL copy rob_entry_id, db_entry_id, txnid and sideband unchanged onto every beat of the line.
REQ-017 SHALL assert last only on beat BEAT_NUM-1; the beat counter is $clog2(BEAT_NUM) bits and wraps to 0 after last.
REQ-018 SHALL hold out_pld stable while out_vld&&!out_rdy; the beat advances only on handshake.
REQ-019 SHALL drive busy = (state==SEND) || any buffer entry valid.

Reset
REQ-020 SHALL, on rst_n low, immediately force out_vld=0, busy=0, state=IDLE, beat counter=0, all buffer-valid flags=0, and in_rdy=1.
REQ-021 SHALL discard any partially sent line on mid-transfer reset; out_pld is don't-care (data not reset) while out_vld=0.

Configuration
REQ-022 SHALL, with EVICT_SER_DOUBLE_BUF_EN defined, provide two line entries: in_rdy=1 whenever the pending entry is free, so a second line can be accepted during SEND and back-to-back lines stream with zero bubble cycles (simultaneous accept and last-beat handshake both take effect).
REQ-023 SHALL, without EVICT_SER_DOUBLE_BUF_EN, provide one entry: in_rdy=1 only in IDLE, giving at most one line per BEAT_NUM+1 cycles.

Structure
REQ-024 SHALL use ram_to_evdb_pld_t, evict_to_ds_pld_t, addr_t and BUS_WIDTH from vector_cache_pkg; SHALL add EVICT_BEAT_NUM (=1024/BUS_WIDTH) to vector_cache_pkg.
REQ-025 SHALL be a single module; no sub-module.

Verification
REQ-026 Single line, offset 0, data beat k = {16{8'hk}}, out_rdy=1 -> 8 beats on consecutive cycles starting the cycle after accept, offsets 0x00..0x70, last only on beat 7.
REQ-027 Offset 0x1F8 -> beat offsets 0x1F8, 0x008 (wrap), 0x018, ... 0x068; tag and index unchanged.
REQ-028 out_rdy toggles 1,0,0,1 repeatedly -> no beat lost or duplicated; out_pld constant during stalls.
REQ-029 Two lines, in_vld held high, DOUBLE_BUF_EN -> 16 contiguous beats, second in_rdy pulse during SEND; without macro -> 1 idle cycle between lines, in_rdy low during SEND.
REQ-030 Reset asserted at beat 3 -> out_vld=0 and busy=0 immediately; next line after release starts at beat 0, offset = req offset.
REQ-031 rob_entry_id=6'h2A, db_entry_id=5'h13, sideband=10'h3FF -> identical on all 8 beats.
